// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: load-use stalls,
// taken-branch flushes, data-memory freeze with timeout watchdog, and debug counters.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      id_inst_i,
  input  logic [31:0]      ex_inst_i,
  input  logic             ex_mem_read_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_TO  = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic [6:0]        id_op;
  logic [4:0]        id_rs1, id_rs2, ex_rd;
  logic              uses_rs1, uses_rs2;
  logic              unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign id_op  = id_inst_i[6:0];
  assign id_rs1 = id_inst_i[19:15];
  assign id_rs2 = id_inst_i[24:20];
  assign ex_rd  = ex_inst_i[11:7];
  assign unused_bits = ^{id_inst_i[31:25], id_inst_i[14:7], ex_inst_i[31:12], ex_inst_i[6:0]};

  // I-type ALU and loads have an immediate in the rs2 field, so only R/S/B use rs2
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_op)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_mem_read_i && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    exmem_write_o = 1'b1;
    if (!rst_n_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
    end else if (dmem_busy_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (dmem_busy_i)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (!dmem_busy_i) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Watchdog: timeout latches on the busy edge that would bring the count to MAX_WAIT
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (!dmem_busy_i) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (dmem_busy_i && (wait_cnt == WAIT_TO)) begin
        timeout_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o)  stall_cnt_o <= sat_inc(stall_cnt_o);
      if (ifid_flush_o) flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, memory freeze, timeout,
// counter saturation and asynchronous reset.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MAX_WAIT = 4;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] LW_X5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X5   = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] SW_X5    = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] ADDI_I5  = 32'h00500313; // addi x6,x0,5
  localparam logic [31:0] ADDI_X0  = 32'h00100313; // addi x6,x0,1

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      id_inst, ex_inst;
  logic             ex_mem_read, branch_taken, dmem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             timeout;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_inst_i(id_inst), .ex_inst_i(ex_inst),
    .ex_mem_read_i(ex_mem_read), .branch_taken_i(branch_taken), .dmem_busy_i(dmem_busy),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_write_o(idex_write), .idex_bubble_o(idex_bubble), .exmem_write_o(exmem_write),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
    .timeout_o(timeout), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, 32'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}),
        32'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    id_inst = NOP; ex_inst = NOP;
    ex_mem_read = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk_ctl("reset_ctl", 6'b000000);
    chk("reset_stall", 32'(stall_cnt), 0);
    chk("reset_state", 32'(state), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk_ctl("run_idle", 6'b110101);

    // load-use on rs1: one bubble, then clear
    ex_inst = LW_X5; ex_mem_read = 1'b1; id_inst = ADD_X5;
    #1;
    chk_ctl("loaduse_rs1", 6'b000111);
    cyc();
    chk("loaduse_stall_cnt", 32'(stall_cnt), 1);
    ex_inst = 32'h0; ex_mem_read = 1'b0;
    #1;
    chk_ctl("after_bubble", 6'b110101);
    cyc();
    chk("after_bubble_cnt", 32'(stall_cnt), 1);

    // rs2 hazard and false-hazard cases (no edges in between)
    ex_inst = LW_X5; ex_mem_read = 1'b1; id_inst = SW_X5;
    #1;
    chk_ctl("loaduse_rs2", 6'b000111);
    id_inst = ADDI_I5;
    #1;
    chk_ctl("no_hazard_imm", 6'b110101);
    ex_inst = LW_X0; id_inst = ADDI_X0;
    #1;
    chk_ctl("no_hazard_x0", 6'b110101);
    ex_inst = LW_X5; ex_mem_read = 1'b0; id_inst = ADD_X5;
    #1;
    chk_ctl("no_hazard_noload", 6'b110101);
    cyc();
    chk("no_hazard_cnt", 32'(stall_cnt), 1);

    // taken branch overrides load-use
    pulse_reset();
    ex_inst = LW_X5; ex_mem_read = 1'b1; id_inst = ADD_X5; branch_taken = 1'b1;
    #1;
    chk_ctl("branch_ctl", 6'b111111);
    cyc();
    chk("branch_flush_cnt", 32'(flush_cnt), 1);
    chk("branch_stall_cnt", 32'(stall_cnt), 0);
    idle_inputs();

    // memory freeze with branch held high for 5 cycles
    pulse_reset();
    branch_taken = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_ctl("freeze_ctl", 6'b000000);
      cyc();
      chk("freeze_state", 32'(state), 1);
    end
    chk("freeze_stall_cnt", 32'(stall_cnt), 5);
    chk("freeze_flush_cnt0", 32'(flush_cnt), 0);
    dmem_busy = 1'b0;
    #1;
    chk_ctl("unfreeze_branch", 6'b111111);
    cyc();
    chk("unfreeze_state", 32'(state), 0);
    chk("unfreeze_flush_cnt", 32'(flush_cnt), 1);
    idle_inputs();

    // timeout watchdog
    pulse_reset();
    chk("to_cleared", 32'(timeout), 0);
    dmem_busy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("to_edge", 32'(timeout), (k >= MAX_WAIT) ? 1 : 0);
    end
    dmem_busy = 1'b0;
    cyc();
    chk("to_sticky", 32'(timeout), 1);
    chk("to_stall_cnt", 32'(stall_cnt), 10);
    chk("to_state_run", 32'(state), 0);

    // counter saturation at all-ones
    dmem_busy = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("stall_sat", 32'(stall_cnt), 15);
    dmem_busy = 1'b0; branch_taken = 1'b1;
    for (int k = 0; k < 17; k++) cyc();
    chk("flush_sat", 32'(flush_cnt), 15);
    idle_inputs();

    // async reset in the middle of a memory wait
    pulse_reset();
    dmem_busy = 1'b1;
    cyc();
    cyc();
    chk("mid_wait_state", 32'(state), 1);
    rst_n = 1'b0;
    #1;
    chk_ctl("async_rst_ctl", 6'b000000);
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_stall", 32'(stall_cnt), 0);
    chk("async_rst_flush", 32'(flush_cnt), 0);
    chk("async_rst_to", 32'(timeout), 0);
    dmem_busy = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_ctl("post_rst_ctl", 6'b110101);
    cyc();
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_stall", 32'(stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
